hazard_sched: RTL
=================

Name: hazard_sched

Overview:
- Central hazard controller and scheduler for the 5-stage redirect pipeline.
- Watches register-use fields in ID and destination/load info in the ID/EX, EX/MEM and MEM/WB registers.
- Produces redirect (forwarding) selects for ID-stage operands, enables/clears for PC, IF/ID and ID/EX, and the halt sequence.
- Keeps saturating stall and flush event counters for performance readout.

Parameters:
- CNT_W, 32, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_rd  in  5  destination of instruction in EX
- ex_we  in  1  EX instruction writes register file
- ex_ld  in  1  EX instruction is a load
- mem_rd  in  5  destination of instruction in MEM
- mem_we  in  1  MEM instruction writes register file
- mem_ld  in  1  MEM instruction is a load
- wb_rd  in  5  destination of instruction in WB
- wb_we  in  1  WB instruction writes register file
- br_taken  in  1  branch/jump resolved taken in EX (redirect PC)
- halt_req  in  1  syscall/halt instruction in EX
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID register enable
- ifid_clr  out  1  IF/ID synchronous clear (bubble)
- idex_clr  out  1  ID/EX synchronous clear (bubble)
- fwd_rs  out  2  rs source: 0 regfile, 1 EX aluout, 2 MEM aluout, 3 WB data
- fwd_rt  out  2  rt source, same encoding as fwd_rs
- halted  out  1  pipeline halted
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  taken-redirect flushes

Behaviour:
- Match definitions:
  - match_X(r) = X_we & (X_rd == r) & (r != 0). Register 0 never matches.
  - A match is considered only when the corresponding id_use_* bit is 1.
- Forwarding (combinational):
  - Priority: EX > MEM > WB > regfile.
  - The EX source is selected only if ex_ld=0; the MEM source only if mem_ld=0.
  - A load match in EX or MEM still blocks lower-priority sources; that case is handled by a stall.
- Load-use stall (combinational):
  - lu = (ex_ld & match_EX) | (mem_ld & match_MEM), evaluated for rs or rt.
  - A load in EX gives 2 stall cycles; a load in MEM gives 1. The load then forwards from WB.
  - While lu: pc_en=0, ifid_en=0, idex_clr=1, ifid_clr=0.
- Redirect: br_taken=1 gives pc_en=1, ifid_en=1, ifid_clr=1, idex_clr=1. Redirect overrides lu in the same cycle.
- FSM states: RUN, HALT. Reset state is RUN.
  - RUN to HALT: on a clock edge with halt_req=1 (and rst=1).
  - In the halt_req cycle itself: pc_en=0, ifid_clr=1, idex_clr=1. halt_req outranks br_taken and lu.
  - HALT: pc_en=0, ifid_en=0, ifid_clr=0, idex_clr=1, halted=1.
  - HALT is left only via reset. All inputs are ignored in HALT except forwarding, which keeps working.
- No hazard in RUN: pc_en=1, ifid_en=1, ifid_clr=0, idex_clr=0.
- Counters (registered):
  - stall_cnt +1 on each edge where state=RUN, lu=1, br_taken=0, halt_req=0.
  - flush_cnt +1 on each edge where state=RUN, br_taken=1, halt_req=0.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Neither counter changes in HALT.
- Reset (rst=0, asynchronous, mid-operation included):
  - State goes to RUN; halted=0, stall_cnt=0, flush_cnt=0 immediately.
  - While rst=0, forced outputs: pc_en=0, ifid_en=0, ifid_clr=1, idex_clr=1, fwd_rs=0, fwd_rt=0.
  - The first edge after rst rises operates normally.
- Latency: control outputs are combinational from inputs and state. State and counters update one edge later.

Test Plan:
- rs=5 used; ex_rd=5 ex_we=1 ex_ld=0; mem_rd=5 mem_we=1 -> fwd_rs=1 (EX wins), no stall.
- lw $8 then immediate use of rt=8: cycle 1 ex_ld match gives pc_en=0 and idex_clr=1. Cycle 2 mem_ld match stalls again. Cycle 3 gives fwd_rt=3, pc_en=1. stall_cnt ends at 2.
- id_rs=0, ex_rd=0, ex_we=1, ex_ld=1 -> fwd_rs=0, no stall, stall_cnt unchanged.
- br_taken=1 together with a load-use match -> ifid_clr=1, idex_clr=1, pc_en=1; flush_cnt +1, stall_cnt +0.
- halt_req=1 with br_taken=1 -> pc_en=0 that cycle. Next cycle halted=1 with idex_clr=1 held. flush_cnt unchanged. Further br_taken pulses do not count.
- CNT_W=2: 5 stall cycles -> stall_cnt sticks at 3. Pulse rst=0 mid-stall -> counters 0, halted=0 asynchronously, pc_en=0 while in reset.

Source files
------------

// File: rtl/hazard_sched_if.sv
// Hazard controller bundle: ID/EX/MEM/WB register-use info toward the scheduler,
// and the forwarding selects, pipeline enables/clears and counters back.
interface hazard_sched_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       ex_rd;
  logic             ex_we;
  logic             ex_ld;
  logic [4:0]       mem_rd;
  logic             mem_we;
  logic             mem_ld;
  logic [4:0]       wb_rd;
  logic             wb_we;
  logic             br_taken;
  logic             halt_req;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_clr;
  logic             idex_clr;
  logic [1:0]       fwd_rs;
  logic [1:0]       fwd_rt;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_rd, ex_we, ex_ld, mem_rd, mem_we, mem_ld, wb_rd, wb_we,
    output br_taken, halt_req,
    input  pc_en, ifid_en, ifid_clr, idex_clr, fwd_rs, fwd_rt,
    input  halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_rd, ex_we, ex_ld, mem_rd, mem_we, mem_ld, wb_rd, wb_we,
    input  br_taken, halt_req,
    output pc_en, ifid_en, ifid_clr, idex_clr, fwd_rs, fwd_rt,
    output halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Central hazard controller for the 5-stage redirect pipeline: operand forwarding,
// load-use stalls, taken-branch flushes, halt sequencing and saturating event counters.
module hazard_sched #(
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst,
  hazard_sched_if.slave bus
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic rs_ex, rs_mem, rs_wb;
  logic rt_ex, rt_mem, rt_wb;
  logic lu;
  logic stall_inc;
  logic flush_inc;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_clr;
  logic       idex_clr;
  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;

  // Register 0 is hardwired, so it never produces a dependency.
  assign rs_ex  = bus.id_use_rs & bus.ex_we  & (bus.ex_rd  == bus.id_rs) & (bus.id_rs != 5'd0);
  assign rs_mem = bus.id_use_rs & bus.mem_we & (bus.mem_rd == bus.id_rs) & (bus.id_rs != 5'd0);
  assign rs_wb  = bus.id_use_rs & bus.wb_we  & (bus.wb_rd  == bus.id_rs) & (bus.id_rs != 5'd0);
  assign rt_ex  = bus.id_use_rt & bus.ex_we  & (bus.ex_rd  == bus.id_rt) & (bus.id_rt != 5'd0);
  assign rt_mem = bus.id_use_rt & bus.mem_we & (bus.mem_rd == bus.id_rt) & (bus.id_rt != 5'd0);
  assign rt_wb  = bus.id_use_rt & bus.wb_we  & (bus.wb_rd  == bus.id_rt) & (bus.id_rt != 5'd0);

  assign lu = ((rs_ex | rt_ex) & bus.ex_ld) | ((rs_mem | rt_mem) & bus.mem_ld);

  // A matching load still shadows older producers; the stall covers that case.
  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem,
                                         input logic m_wb, input logic ld_ex,
                                         input logic ld_mem);
    logic [1:0] sel;
    sel = 2'd0;
    if (m_ex)       sel = ld_ex  ? 2'd0 : 2'd1;
    else if (m_mem) sel = ld_mem ? 2'd0 : 2'd2;
    else if (m_wb)  sel = 2'd3;
    return sel;
  endfunction

  always_comb begin
    fwd_rs = 2'd0;
    fwd_rt = 2'd0;
    if (rst) begin
      fwd_rs = fwd_sel(rs_ex, rs_mem, rs_wb, bus.ex_ld, bus.mem_ld);
      fwd_rt = fwd_sel(rt_ex, rt_mem, rt_wb, bus.ex_ld, bus.mem_ld);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Halt outranks redirect, which outranks the load-use stall.
  always_comb begin
    state_next = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_clr   = 1'b0;
    idex_clr   = 1'b0;
    if (!rst) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (bus.halt_req) begin
            state_next = HALT;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_clr   = 1'b1;
            idex_clr   = 1'b1;
          end else if (bus.br_taken) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
          end else if (lu) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
          end
        end
        HALT: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_clr = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign stall_inc = (state == RUN) & lu & ~bus.br_taken & ~bus.halt_req;
  assign flush_inc = (state == RUN) & bus.br_taken & ~bus.halt_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && stall_q != CNT_MAX) stall_q <= stall_q + 1'b1;
      if (flush_inc && flush_q != CNT_MAX) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.ifid_en   = ifid_en;
  assign bus.ifid_clr  = ifid_clr;
  assign bus.idex_clr  = idex_clr;
  assign bus.fwd_rs    = fwd_rs;
  assign bus.fwd_rt    = fwd_rt;
  assign bus.halted    = (state == HALT);
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule
